// File: rtl/mips_wb_pkg.sv
// Shared types for the write buffer: entry layout, drain FSM states and
// byte-lane width helper.
package mips_wb_pkg;

  // Byte-lane count for a data bus of the given width.
  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

  // Default-width view of one buffered store.
  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_BE_W   = be_w(WB_DATA_W);

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
    logic [WB_BE_W-1:0]   be;
  } wb_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } drain_state_t;

endpackage

// File: rtl/mips_wb_fwd_search.sv
// Store-to-load forwarding lookup: scans valid entries from youngest
// (tail-1) to oldest and reports the first address match.
module mips_wb_fwd_search
  import mips_wb_pkg::*;
#(
  parameter int BUF_BITS = 3,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic [(2**BUF_BITS)-1:0][ADDR_W-1:0]   entry_addr,
  input  logic [(2**BUF_BITS)-1:0][DATA_W-1:0]   entry_data,
  input  logic [(2**BUF_BITS)-1:0][DATA_W/8-1:0] entry_be,
  input  logic [(2**BUF_BITS)-1:0]               valid,
  input  logic [BUF_BITS-1:0]                    tail,
  input  logic [ADDR_W-1:0]                      fwd_addr,
  output logic                                   hit,
  output logic                                   partial,
  output logic [DATA_W-1:0]                      data
);

  localparam int DEPTH = 2 ** BUF_BITS;
  localparam int BE_W  = be_w(DATA_W);

  logic                found;
  logic [BUF_BITS-1:0] idx;

  // Youngest-first priority scan; k == DEPTH wraps to the oldest slot.
  always_comb begin
    hit     = 1'b0;
    partial = 1'b0;
    data    = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      idx = tail - BUF_BITS'(k);
      if (!found && valid[idx] && (entry_addr[idx] == fwd_addr)) begin
        found = 1'b1;
        data  = entry_data[idx];
        if (entry_be[idx] == {BE_W{1'b1}}) hit = 1'b1;
        else                               partial = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mips_cache_writebuffer_merge.sv
// Store write buffer in front of an Avalon-MM master write port: circular
// FIFO with merging into the youngest entry, forwarding lookup and a
// drain hold so reads can borrow the bus.
module mips_cache_writebuffer_merge
  import mips_wb_pkg::*;
#(
  parameter int BUF_BITS = 3,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter bit MERGE_EN = 1'b1,
  parameter bit FWD_EN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_write,
  input  logic [ADDR_W-1:0]     in_addr,
  input  logic [DATA_W-1:0]     in_writedata,
  input  logic [DATA_W/8-1:0]   in_byteenable,
  output logic                  in_accept,
  output logic                  full,
  output logic                  empty,
  output logic [BUF_BITS:0]     count,
  input  logic                  hold,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_write,
  output logic [DATA_W-1:0]     avm_writedata,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  input  logic                  avm_waitrequest,
  input  logic [ADDR_W-1:0]     fwd_addr,
  output logic                  fwd_hit,
  output logic                  fwd_partial,
  output logic [DATA_W-1:0]     fwd_data
);

  localparam int DEPTH = 2 ** BUF_BITS;
  localparam int BE_W  = be_w(DATA_W);
  localparam int CNT_W = BUF_BITS + 1;

  logic [DEPTH-1:0][ADDR_W-1:0] e_addr;
  logic [DEPTH-1:0][DATA_W-1:0] e_data;
  logic [DEPTH-1:0][BE_W-1:0]   e_be;
  logic [DEPTH-1:0]             e_valid;

  logic [BUF_BITS-1:0] head, tail, tail_m1, ld_idx;
  drain_state_t        state, state_nxt;
  logic                merge_case, do_merge, do_push, pop, load;
  logic [DATA_W-1:0]   merged_data, ld_data, s_data;
  logic [BE_W-1:0]     merged_be, ld_be;
  logic                s_hit, s_partial;

  // New bytes replace old ones only on enabled lanes.
  function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_d,
                                                    input logic [DATA_W-1:0] new_d,
                                                    input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] r;
    r = old_d;
    for (int b = 0; b < BE_W; b++)
      if (be[b]) r[b*8 +: 8] = new_d[b*8 +: 8];
    return r;
  endfunction

  assign tail_m1 = tail - BUF_BITS'(1);
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));

  // The sole entry already on the bus must not change under the slave.
  assign merge_case = MERGE_EN && !empty && (in_addr == e_addr[tail_m1]) &&
                      !((state == ISSUE) && (count == CNT_W'(1)));
  assign do_merge   = in_write && merge_case;
  assign do_push    = in_write && !merge_case && !full;
  assign in_accept  = do_merge || do_push;

  assign merged_data = merge_lanes(e_data[tail_m1], in_writedata, in_byteenable);
  assign merged_be   = e_be[tail_m1] | in_byteenable;

  // A merge landing on the entry being loaded this edge must reach the bus.
  assign ld_data = (do_merge && (ld_idx == tail_m1)) ? merged_data : e_data[ld_idx];
  assign ld_be   = (do_merge && (ld_idx == tail_m1)) ? merged_be   : e_be[ld_idx];

  // Entry storage: push writes the tail slot, merge rewrites the youngest slot.
  always_ff @(posedge clk) begin
    if (do_push) begin
      e_addr[tail] <= in_addr;
      e_data[tail] <= in_writedata;
      e_be[tail]   <= in_byteenable;
    end else if (do_merge) begin
      e_data[tail_m1] <= merged_data;
      e_be[tail_m1]   <= merged_be;
    end
  end

  // Ring pointers and occupancy; push and pop on one edge cancel in count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + BUF_BITS'(1);
      if (pop)     head <= head + BUF_BITS'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(pop);
    end
  end

  // Drain FSM next state: hold only gates starting a new write.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    ld_idx    = head;
    case (state)
      IDLE: begin
        if (!empty && !hold) begin
          state_nxt = ISSUE;
          load      = 1'b1;
        end
      end
      ISSUE: begin
        if (!avm_waitrequest) begin
          pop = 1'b1;
          if ((count > CNT_W'(1)) && !hold) begin
            load   = 1'b1;
            ld_idx = head + BUF_BITS'(1);
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Drain FSM state and registered Avalon outputs, held while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      avm_write      <= 1'b0;
      avm_address    <= '0;
      avm_writedata  <= '0;
      avm_byteenable <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        avm_write      <= 1'b1;
        avm_address    <= e_addr[ld_idx];
        avm_writedata  <= ld_data;
        avm_byteenable <= ld_be;
      end else if (state_nxt == IDLE) begin
        avm_write <= 1'b0;
      end
    end
  end

  // Slot i is live when its distance from head is below the occupancy.
  always_comb begin
    e_valid = '0;
    for (int i = 0; i < DEPTH; i++)
      e_valid[i] = ({1'b0, BUF_BITS'(i) - head} < count);
  end

  mips_wb_fwd_search #(
    .BUF_BITS (BUF_BITS),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W)
  ) u_fwd (
    .entry_addr (e_addr),
    .entry_data (e_data),
    .entry_be   (e_be),
    .valid      (e_valid),
    .tail       (tail),
    .fwd_addr   (fwd_addr),
    .hit        (s_hit),
    .partial    (s_partial),
    .data       (s_data)
  );

  assign fwd_hit     = FWD_EN ? s_hit     : 1'b0;
  assign fwd_partial = FWD_EN ? s_partial : 1'b0;
  assign fwd_data    = FWD_EN ? s_data    : '0;

endmodule
